// File: rtl/seg7_scan_driver_if.sv
// Display bus from the clock/calendar controller: digit nibbles plus blink and decimal-point masks.
interface seg7_scan_driver_if;
    logic [31:0] Disp_Data;
    logic [7:0]  Blink_Mask;
    logic [7:0]  Dp_Mask;

    modport master (output Disp_Data, output Blink_Mask, output Dp_Mask);
    modport slave  (input  Disp_Data, input  Blink_Mask, input  Dp_Mask);
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode 7-segment scanner: per-frame snapshot of the display bus, hex decode, blink.
// Optional macro SEG7_SCAN_DIM_EN adds the Bright input and PWM dimming of the digit selects.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV  = 50_000 - 1,
    parameter int unsigned BLINK_DIV = 25_000_000 - 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    seg7_scan_driver_if.slave bus,
`ifdef SEG7_SCAN_DIM_EN
    input  logic [2:0]        Bright,
`endif
    output logic [7:0]        SEL,
    output logic [7:0]        SEG,
    output logic              Frame_Start
);

    localparam int SCAN_W  = (SCAN_DIV  > 0) ? $clog2(SCAN_DIV  + 1) : 1;
    localparam int BLINK_W = (BLINK_DIV > 0) ? $clog2(BLINK_DIV + 1) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'(SCAN_DIV);
    localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_DIV);

    logic [SCAN_W-1:0]  scan_cnt_q,    scan_cnt_d;
    logic [2:0]         idx_q,         idx_d;
    logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [31:0]        data_q,        data_d;
    logic [7:0]         blink_mask_q,  blink_mask_d;
    logic [7:0]         dp_mask_q,     dp_mask_d;
    logic [7:0]         sel_q,         sel_d;
    logic [7:0]         seg_q,         seg_d;
    logic               frame_start_q, frame_start_d;
`ifdef SEG7_SCAN_DIM_EN
    logic [2:0]         pwm_q,         pwm_d;
`endif

    logic       scan_wrap;
    logic       frame_wrap;
    logic [7:0] digit_onehot;
    logic [3:0] nibble;

    // Active-high segments g..a for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h3F;  4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;  4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;  4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;  4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;  4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;  4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;  4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;  default: hex_to_seg = 7'h71;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_onehot[gi] = (idx_d == 3'(gi));
        end
    endgenerate

    // Outputs are built from next-state values so they change on the same edge as the
    // digit index, and digit 0 of a new frame already shows the fresh snapshot.
    always_comb begin
        scan_wrap     = (scan_cnt_q == SCAN_TC);
        frame_wrap    = scan_wrap && (idx_q == 3'd7);
        scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        idx_d         = scan_wrap ? idx_q + 3'd1 : idx_q;

        blink_cnt_d   = (blink_cnt_q == BLINK_TC) ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q ^ (blink_cnt_q == BLINK_TC);

        data_d        = frame_wrap ? bus.Disp_Data  : data_q;
        blink_mask_d  = frame_wrap ? bus.Blink_Mask : blink_mask_q;
        dp_mask_d     = frame_wrap ? bus.Dp_Mask    : dp_mask_q;

        nibble        = data_d[{idx_d, 2'b00} +: 4];
        if (blink_phase_d && |(digit_onehot & blink_mask_d))
            seg_d = 8'hFF;
        else
            seg_d = {~|(digit_onehot & dp_mask_d), ~hex_to_seg(nibble)};

        sel_d         = ~digit_onehot;
`ifdef SEG7_SCAN_DIM_EN
        pwm_d         = pwm_q + 3'd1;
        if (pwm_d > Bright)
            sel_d = 8'hFF;
`endif
        frame_start_d = (scan_cnt_d == SCAN_TC) && (idx_d == 3'd7);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scan_cnt_q    <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            data_q        <= '0;
            blink_mask_q  <= '0;
            dp_mask_q     <= '0;
            sel_q         <= 8'hFF;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
`ifdef SEG7_SCAN_DIM_EN
            pwm_q         <= '0;
`endif
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            data_q        <= data_d;
            blink_mask_q  <= blink_mask_d;
            dp_mask_q     <= dp_mask_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
`ifdef SEG7_SCAN_DIM_EN
            pwm_q         <= pwm_d;
`endif
        end
    end

    assign SEL         = sel_q;
    assign SEG         = seg_q;
    assign Frame_Start = frame_start_q;

endmodule
